pipelined_shifter: RTL and testbench
====================================

// Module: pipelined_shifter
// PURPOSE
//   Parametrised, pipelined barrel shifter for the ALU datapath. It supports four
//   modes: SLL, SRA, ROR and SRL.
//   It has log2(WIDTH) registered stages, and stage k conditionally shifts by 2^k.
//   A valid/ready handshake runs on both sides, with bubble-collapsing backpressure
//   and a synchronous flush.
//   It sits between the operand-forward muxes and the EX/MEM result select, and
//   gives a sustained throughput of one result per cycle.
// PARAMETERS
//   WIDTH    16               data width; power of 2, >= 4
//   SHAMT_W  $clog2(WIDTH)    shift-amount width and number of pipeline stages (derived)
// PORTS
//   clk        in   1        single clock; all state updates on posedge
//   rst_n      in   1        asynchronous, active-low reset
//   flush      in   1        synchronous kill of all in-flight operations
//   in_valid   in   1        input operation valid
//   in_ready   out  1        pipeline can accept an operation this cycle
//   in_data    in   WIDTH    operand to shift
//   in_shamt   in   SHAMT_W  shift amount, 0..WIDTH-1
//   in_mode    in   2        00=SLL, 01=SRA, 10=ROR, 11=SRL
//   out_valid  out  1        result valid (registered, last stage)
//   out_ready  in   1        consumer accepts result this cycle
//   out_data   out  WIDTH    shifted result (registered)
//   out_zero   out  1        out_data == 0, registered together with out_data
// BEHAVIOUR
//   Reset
//   - rst_n low clears every stage valid bit, and all data, shamt and mode registers, to 0.
//   - out_valid=0, out_data=0, out_zero=0.
//   - in_ready is combinational and is 1 while in reset-idle.
//   Stage structure
//   - Stage k (k=0..SHAMT_W-1) registers data, remaining shamt bits, mode and valid.
//   - Stage k shifts by 2^k when shamt[k]=1 and passes the value through otherwise.
//   - Stage SHAMT_W-1 is the output register.
//   Mode rules per stage, with the shift amount s = 2^k
//   - SLL: the low s bits are zero-filled.
//   - SRL: the high s bits are zero-filled.
//   - SRA: the high s bits are filled with the current stage input's MSB.
//   - ROR: the bits shifted out of the LSB end re-enter at the MSB end.
//   - shamt=0 passes the operand unchanged in every mode.
//   - No shamt >= WIDTH case exists, since the port is SHAMT_W bits wide.
//   Advance rule (bubble-collapsing)
//   - adv[last] = ~valid[last] | out_ready
//   - adv[k]    = ~valid[k] | adv[k+1]
//   - in_ready  = adv[0]
//   - A stage whose adv is 1 loads from its upstream stage. Stage 0 loads in_valid & in_ready.
//   - A stage whose adv is 0 holds all of its contents.
//   Timing and ordering
//   - Latency is SHAMT_W cycles from accept to out_valid when there is no stall.
//   - Throughput is 1 operation per cycle while out_ready=1.
//   - Results leave in strict acceptance order. Nothing is dropped or duplicated.
//   Capacity and stall
//   - The pipeline holds at most SHAMT_W operations.
//   - With out_ready=0 held, in_ready falls once all stages are valid.
//   Output holding
//   - out_data, out_zero and out_valid are stable while out_valid & ~out_ready.
//   - The output register may change only after a handshake or a flush.
//   Simultaneous events
//   - A handshake on both sides in the same cycle with a full pipe keeps the pipe full
//     and retires exactly one operation.
//   - flush=1 clears all valid bits at the next edge and wins over in_valid that cycle.
//   - in_ready is forced to 0 during flush. Data registers may keep stale values.
//   Reset mid-operation
//   - In-flight operations are discarded. No out_valid appears until a new accept plus
//     SHAMT_W cycles.
//   Input contract
//   - in_data, in_shamt and in_mode only need to be stable in cycles where
//     in_valid & in_ready.
// TESTING  (WIDTH=16, so 4 stages)
//   1. SLL 0x0001 by 15 -> 0x8000, out_valid exactly 4 cycles after accept. SRL 0x8000 by 15 -> 0x0001.
//   2. SRA 0x8000 by 15 -> 0xFFFF. SRA 0x7F00 by 8 -> 0x007F. SRA 0xF0F0 by 0 -> 0xF0F0.
//   3. ROR 0x1234 by 4 -> 0x4123. ROR 0x8001 by 1 -> 0xC000. SLL 0x8000 by 1 -> 0x0000 with out_zero=1.
//   4. Back-to-back ops with mixed modes and out_ready=1: one result per cycle, in order,
//      matching a reference model. Random stalls must give the same sequence.
//   5. out_ready=0 with 6 ops offered: 4 accepted, in_ready=0 afterwards, out_data held
//      stable. Release: remaining 2 accepted, all 6 delivered in order.
//   6. Flush with 3 ops in flight plus an in_valid in the same cycle: none appear on the
//      output. rst_n pulsed low mid-stream: out_valid=0 and out_data=0 immediately.

Source files
------------

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit.
// Stage k shifts by 2^k when its shamt bit is set. Valid/ready on both sides
// with bubble-collapsing backpressure and a synchronous flush.
module pipelined_shifter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_SRL = 2'b11;

  // The last stage is the output register and needs no shamt/mode copy.
  logic [SHAMT_W-1:0] r_valid;
  logic [WIDTH-1:0]   r_data  [SHAMT_W];
  logic [SHAMT_W-1:0] r_shamt [SHAMT_W-1];
  logic [1:0]         r_mode  [SHAMT_W-1];
  logic               r_zero;

  logic [SHAMT_W-1:0] w_adv;
  logic [SHAMT_W-1:0] w_src_valid;
  logic [WIDTH-1:0]   w_src_data  [SHAMT_W];
  logic [SHAMT_W-1:0] w_src_shamt [SHAMT_W];
  logic [1:0]         w_src_mode  [SHAMT_W];
  logic [WIDTH-1:0]   w_res       [SHAMT_W];

  // Advance: a stage may load unless it and every stage downstream are full
  // and the consumer is stalling (closed form of the ripple chain).
  always_comb begin
    logic v_full;
    v_full = 1'b1;
    w_adv  = '0;
    for (int k = SHAMT_W - 1; k >= 0; k--) begin
      v_full   = v_full & r_valid[k];
      w_adv[k] = out_ready | ~v_full;
    end
  end

  assign in_ready = w_adv[0] & ~flush;

  // Per-stage source selection and conditional shift by 2^k.
  always_comb begin
    w_src_valid[0] = in_valid & in_ready;
    w_src_data[0]  = in_data;
    w_src_shamt[0] = in_shamt;
    w_src_mode[0]  = in_mode;
    for (int k = 1; k < SHAMT_W; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_shamt[k] = r_shamt[k-1];
      w_src_mode[k]  = r_mode[k-1];
    end
    for (int k = 0; k < SHAMT_W; k++) begin
      w_res[k] = w_src_data[k];
      if (w_src_shamt[k][k]) begin
        case (w_src_mode[k])
          MODE_SLL: w_res[k] = w_src_data[k] << (1 << k);
          MODE_SRA: w_res[k] = $signed(w_src_data[k]) >>> (1 << k);
          MODE_ROR: w_res[k] = (w_src_data[k] >> (1 << k)) |
                               (w_src_data[k] << (WIDTH - (1 << k)));
          MODE_SRL: w_res[k] = w_src_data[k] >> (1 << k);
          default:  w_res[k] = w_src_data[k];
        endcase
      end
    end
  end

  // Stage registers: flush kills valids; a stalled stage holds everything.
  // Payload only loads with a valid op so bubbles do not disturb held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_zero  <= 1'b0;
      for (int k = 0; k < SHAMT_W; k++) begin
        r_data[k] <= '0;
      end
      for (int k = 0; k < SHAMT_W - 1; k++) begin
        r_shamt[k] <= '0;
        r_mode[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < SHAMT_W; k++) begin
        if (flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_adv[k]) begin
          r_valid[k] <= w_src_valid[k];
          if (w_src_valid[k]) begin
            r_data[k] <= w_res[k];
          end
        end
      end
      for (int k = 0; k < SHAMT_W - 1; k++) begin
        if (!flush && w_adv[k] && w_src_valid[k]) begin
          r_shamt[k] <= w_src_shamt[k];
          r_mode[k]  <= w_src_mode[k];
        end
      end
      if (!flush && w_adv[SHAMT_W-1] && w_src_valid[SHAMT_W-1]) begin
        r_zero <= (w_res[SHAMT_W-1] == '0);
      end
    end
  end

  assign out_valid = r_valid[SHAMT_W-1];
  assign out_data  = r_data[SHAMT_W-1];
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed + random bench for pipelined_shifter (WIDTH=16) with a scoreboard queue.
module tb_pipelined_shifter;
  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_zero;

  typedef struct packed {
    logic [W-1:0] data;
    logic         zero;
  } exp_t;

  exp_t q[$];
  exp_t nx_exp;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_ret   = 0;
  int   n_acc   = 0;
  logic s_acc, s_ov;
  logic p_hold = 1'b0;
  logic [W+1:0] p_out = '0;
  logic rand_stall = 1'b0;

  always #5 clk = ~clk;

  pipelined_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Whole-amount reference, computed bit by bit.
  function automatic logic [W-1:0] ref_shift(logic [W-1:0] d, logic [SW-1:0] s, logic [1:0] m);
    logic [W-1:0] r;
    int si;
    si = int'(s);
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (m)
        2'b00: r[i] = (i >= si) ? d[i-si] : 1'b0;
        2'b01: r[i] = (i + si < W) ? d[i+si] : d[W-1];
        2'b10: r[i] = d[(i+si)%W];
        default: r[i] = (i + si < W) ? d[i+si] : 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] m,
                        input logic [W-1:0] e);
    in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m;
    nx_exp.data = e; nx_exp.zero = (e == '0);
  endtask

  task automatic set_rand();
    logic [W-1:0] d; logic [SW-1:0] s; logic [1:0] m;
    d = W'($urandom); s = SW'($urandom_range(0, 15)); m = 2'($urandom_range(0, 3));
    set_op(d, s, m, ref_shift(d, s, m));
  endtask

  // Sample at negedge, score handshakes, then advance past the next posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_acc = in_valid & in_ready;
    s_ov  = out_valid;
    if (p_hold) check("out_hold", {30'd0, out_valid, out_zero} ^ 32'(out_data) << 2,
                      {30'd0, p_out[W+1], p_out[W]} ^ 32'(p_out[W-1:0]) << 2);
    if (out_valid & out_ready) begin
      n_ret++;
      if (q.size() == 0) begin
        check("unexpected_output", 32'(out_data), 32'hDEAD_BEEF);
      end else begin
        e = q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_zero", 32'(out_zero), 32'(e.zero));
      end
    end
    if (flush) q.delete();
    if (s_acc) begin q.push_back(nx_exp); n_acc++; end
    p_hold = out_valid & ~out_ready & ~flush;
    p_out  = {out_valid, out_zero, out_data};
    @(posedge clk); #1;
    if (rand_stall) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_wait(input int budget);
    int n;
    n = 0;
    do begin tick(); n++; end while (!s_acc && n < budget);
    if (!s_acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    in_valid = 1'b0; n = 0;
    while (q.size() > 0 && n < budget) begin tick(); n++; end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int r0, k, cnt;
    logic [W-1:0] d0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_zero",  32'(out_zero),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // 1: latency and end-to-end shifts
    set_op(16'h0001, 4'd15, 2'b00, 16'h8000);
    tick(); check("t1_accept", 32'(s_acc), 32'd1);
    in_valid = 1'b0;
    repeat (3) begin tick(); check("t1_latency_early", 32'(s_ov), 32'd0); end
    tick(); check("t1_latency", 32'(s_ov), 32'd1);
    set_op(16'h8000, 4'd15, 2'b11, 16'h0001); send_wait(10);
    drain(20);

    // 2/3: SRA and ROR corners, zero flag
    set_op(16'h8000, 4'd15, 2'b01, 16'hFFFF); send_wait(10);
    set_op(16'h7F00, 4'd8,  2'b01, 16'h007F); send_wait(10);
    set_op(16'hF0F0, 4'd0,  2'b01, 16'hF0F0); send_wait(10);
    set_op(16'h1234, 4'd4,  2'b10, 16'h4123); send_wait(10);
    set_op(16'h8001, 4'd1,  2'b10, 16'hC000); send_wait(10);
    set_op(16'h8000, 4'd1,  2'b00, 16'h0000); send_wait(10);
    drain(20);

    // 4: back-to-back, then random stalls and gaps
    r0 = n_ret;
    for (int i = 0; i < 24; i++) begin
      set_rand(); tick();
      check("t4_b2b_accept", 32'(s_acc), 32'd1);
    end
    drain(20);
    check("t4_b2b_count", 32'(n_ret - r0), 32'd24);
    r0 = n_ret;
    rand_stall = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      set_rand(); send_wait(50);
    end
    drain(200);
    rand_stall = 1'b0; out_ready = 1'b1;
    check("t4_stall_count", 32'(n_ret - r0), 32'd30);

    // 5: capacity under stall
    r0 = n_ret; out_ready = 1'b0; k = 0;
    set_rand();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_acc) begin
        k++;
        if (k < 6) set_rand(); else in_valid = 1'b0;
      end
    end
    check("t5_accepted", 32'(k), 32'd4);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    d0 = out_data;
    tick(); tick();
    check("t5_data_held", 32'(out_data), 32'(d0));
    out_ready = 1'b1;
    cnt = 0;
    while (k < 6 && cnt < 20) begin
      tick(); cnt++;
      if (s_acc) begin k++; if (k < 6) set_rand(); else in_valid = 1'b0; end
    end
    check("t5_accepted_all", 32'(k), 32'd6);
    drain(20);
    check("t5_delivered", 32'(n_ret - r0), 32'd6);

    // 6: flush with ops in flight plus a same-cycle offer
    out_ready = 1'b0;
    repeat (3) begin set_rand(); send_wait(10); end
    flush = 1'b1; set_rand(); #1;
    check("t6_in_ready_flush", 32'(in_ready), 32'd0);
    tick();
    check("t6_flush_no_accept", 32'(s_acc), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cnt = 0;
    repeat (8) begin tick(); cnt += int'(s_ov); end
    check("t6_no_output", 32'(cnt), 32'd0);

    // Reset mid-stream
    set_op(16'h00FF, 4'd0, 2'b00, 16'h00FF);
    repeat (6) tick();
    in_valid = 1'b0;
    check("rst_mid_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0; #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_data",  32'(out_data),  32'd0);
    q.delete(); p_hold = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
    repeat (6) begin tick(); cnt += int'(s_ov); end
    check("rst_mid_quiet", 32'(cnt), 32'd0);
    set_op(16'h00F0, 4'd4, 2'b00, 16'h0F00);
    tick(); in_valid = 1'b0;
    repeat (3) begin tick(); check("rst_relat_early", 32'(s_ov), 32'd0); end
    tick(); check("rst_relat", 32'(s_ov), 32'd1);
    drain(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
